// File: rtl/regfile_2r1w_pkg.sv
// Shared CPU datapath types for the register file.
// Sweep FSM states and default array geometry.
package cpu_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_SWEEP,
    RF_DONE
  } rf_state_t;

  localparam int RF_WIDTH = 8;
  localparam int RF_DEPTH = 8;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Register file access bundle: write port, two read ports,
// clear handshake and dropped-write flag.
interface regfile_2r1w_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int AW    = $clog2(RF_DEPTH)
);

  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             clr_req;
  logic             clr_busy;
  logic             clr_done;
  logic             wr_drop;

  modport master (
    output we, wa, wd, ra1, ra2, clr_req,
    input  rd1, rd2, clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  we, wa, wd, ra1, ra2, clr_req,
    output rd1, rd2, clr_busy, clr_done, wr_drop
  );

endinterface

// File: rtl/regfile_2r1w_reg_word.sv
// One register file entry: load on we, zero on clr.
// Clear wins over load so a sweep always leaves zero.
module reg_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Entry storage with sync clear and load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with optional x0,
// write bypass and a one-entry-per-cycle clear sweep.
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int WIDTH    = RF_WIDTH,
  parameter int DEPTH    = RF_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_2r1w_if.slave   bus
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

  rf_state_t        state;
  logic [AW-1:0]    idx;
  logic             busy;
  logic             done;
  logic             drop;
  logic             wr_eff;
  logic [DEPTH-1:0] wen;
  logic [DEPTH-1:0] cen;
  logic [WIDTH-1:0] mem [DEPTH];

  assign wr_eff = bus.we
                & (state == RF_IDLE)
                & ({1'b0, bus.wa} < DEPTH_W)
                & ~(ZERO_REG & (bus.wa == '0));

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign wen[i] = wr_eff & (bus.wa == AW'(i));
    assign cen[i] = (state == RF_SWEEP) & (idx == AW'(i));
    reg_word #(.WIDTH(WIDTH)) u_word (
      .clk (clk),
      .rst (rst),
      .we  (wen[i]),
      .clr (cen[i]),
      .d   (bus.wd),
      .q   (mem[i])
    );
  end

  function automatic logic [WIDTH-1:0] rport(
    input logic [AW-1:0] a
  );
    rport = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == AW'(i)) rport = mem[i];
    if (ZERO_REG && a == '0) rport = '0;
    if (BYPASS && wr_eff && a == bus.wa) rport = bus.wd;
  endfunction

  // Combinational read ports with x0 and bypass.
  always_comb begin
    bus.rd1 = rport(bus.ra1);
    bus.rd2 = rport(bus.ra2);
  end

  // Clear sweep FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RF_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      drop  <= 1'b0;
    end else begin
      drop <= bus.we & (state != RF_IDLE);
      done <= 1'b0;
      unique case (state)
        RF_IDLE: begin
          if (bus.clr_req) begin
            state <= RF_SWEEP;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        RF_SWEEP: begin
          if (idx == LAST) begin
            state <= RF_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RF_DONE: state <= RF_IDLE;
        default: state <= RF_IDLE;
      endcase
    end
  end

  assign bus.clr_busy = busy;
  assign bus.clr_done = done;
  assign bus.wr_drop  = drop;

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file for the CPU datapath: a configurable number of words of configurable width, one synchronous write port and two combinational read ports. Adds an optional hardwired-zero entry 0 (RISC-V x0), optional write-to-read bypass, and a sequenced clear command that zeroes the array one entry per cycle with a busy/done handshake. It sits between the instruction decoder (addresses) and the ALU operand muxes, and replaces the earlier discrete write-enabled registers, decoder and 8:1 read mux.

## Interface
Parameters:
- WIDTH, 8, data width of each entry
- DEPTH, 8, number of entries (≥2, need not be a power of 2)
- AW, $clog2(DEPTH), address width
- ZERO_REG, 1, entry 0 reads 0 and ignores writes when 1
- BYPASS, 1, same-cycle write data forwarded to matching read port when 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  WIDTH  write data
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  WIDTH  read data, port 1
- rd2  out  WIDTH  read data, port 2
- clr_req  in  1  request sequenced clear (level, sampled at clock edge)
- clr_busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse when sweep completes
- wr_drop  out  1  one-cycle pulse: write was discarded

## Operation
- Reset (rst=0): all entries 0, FSM IDLE, sweep index 0, clr_busy=0, clr_done=0, wr_drop=0; consequently rd1=rd2=0.
- Write is effective iff we=1, FSM=IDLE, wa<DEPTH and not (ZERO_REG=1 and wa=0). Effective write updates entry wa at rising edge.
- Writes ignored without wr_drop: wa≥DEPTH, or wa=0 with ZERO_REG=1.
- Write with we=1 while FSM≠IDLE: discarded, wr_drop=1 in the following cycle.
- Reads combinational: rdN = entry[raN]; raN≥DEPTH → 0; raN=0 with ZERO_REG=1 → 0.
- Bypass (BYPASS=1): if the write is effective this cycle and wa=raN, rdN=wd. Never applies to a non-effective write. BYPASS=0: rdN shows the old value until after the edge.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE → SWEEP when clr_req=1 at the edge; index←0. Priority: a simultaneous we in that cycle is still effective (FSM=IDLE), then swept.
  - SWEEP: entry[index]←0 each edge; index increments; when index=DEPTH-1 → DONE. clr_req ignored.
  - DONE: clr_done=1 for one cycle → IDLE unconditionally; a held clr_req starts a new sweep from IDLE next edge.
- Reads during SWEEP return current contents (already-cleared entries read 0).
- Reset asserted mid-sweep: immediate return to IDLE with full-array zero, outputs at reset values.

## Timing
- Write latency: 1 edge; read latency: 0 (combinational), bypass 0.
- clr_req sampled at edge E0 → clr_busy=1 from E0 through E0+DEPTH; entry k zeroed at edge E0+1+k; clr_done=1 for the cycle after E0+DEPTH; clr_busy=0 in the DONE cycle.
- Sweep duration: DEPTH cycles busy + 1 cycle done.
- wr_drop: registered, high exactly one cycle after each dropped write cycle.

## Structure
- Shared package cpu_pkg: state enum rf_state_t {RF_IDLE, RF_SWEEP, RF_DONE}; default WIDTH/DEPTH constants.
- Sub-module reg_word: parametrised WIDTH register with write enable, synchronous clear input and async active-low reset; instantiated DEPTH times by generate. Read muxing, bypass and FSM in top level.

## Test plan
- Reset, then write 8'hA5 to entry 3, read ra1=3 next cycle → rd1=8'hA5; ra2=5 → rd2=0.
- ZERO_REG=1: write 8'hFF to entry 0 → rd1 at ra1=0 stays 0, no wr_drop; BYPASS=1 write 8'h3C to entry 2 with ra2=2 same cycle → rd2=8'h3C combinationally.
- Fill all 8 entries, pulse clr_req one cycle → clr_busy high 8 cycles, entries zero in order 0..7, clr_done one-cycle pulse, then clr_busy=0.
- we=1, wa=4, wd=8'h11 during SWEEP → wr_drop pulse next cycle, entry 4 remains 0 after sweep.
- DEPTH=6, write to wa=7 → ignored, ra1=7 reads 0; rst low at sweep cycle 3 → clr_busy=0, all entries 0 immediately.
